// File: rtl/piso_8bit_tx.sv
// Byte-wide parallel-in, serial-out transmitter (MSB first) with a one-entry holding buffer.
// A byte accepted at edge N drives bits during cycles N+1..N+8; din_ready drops only while the buffer is full and not draining.
module piso_8bit_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sout,
  output logic       sout_valid,
  output logic       frame_start,
  output logic [2:0] bit_idx,
  output logic       done,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hold_full_q, hold_full_d;
  logic       done_q, done_d;
  logic       last_bit, load, accept;

  always_comb begin
    last_bit    = (state_q == SHIFT) && (cnt_q == 3'd7);
    // Reloading on the last bit is what makes back-to-back frames gapless.
    load        = hold_full_q && ((state_q == IDLE) || last_bit);
    din_ready   = !hold_full_q || load;
    accept      = din_valid && din_ready;

    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    done_d      = last_bit;

    if (accept) begin
      hold_data_d = din;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end

    if (load) begin
      shreg_d = hold_data_q;
      cnt_d   = 3'd0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      shreg_d = {shreg_q[6:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
      if (last_bit) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= 8'd0;
      cnt_q       <= 3'd0;
      hold_data_q <= 8'd0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
    end
  end

  assign sout        = (state_q == SHIFT) ? shreg_q[7] : 1'b0;
  assign sout_valid  = (state_q == SHIFT);
  assign frame_start = (state_q == SHIFT) && (cnt_q == 3'd0);
  assign bit_idx     = (state_q == SHIFT) ? (3'd7 - cnt_q) : 3'd0;
  assign done        = done_q;
  assign busy        = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_8bit_tx.sv
module tb_piso_8bit_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout, sout_valid, frame_start, done, busy;
  logic [2:0] bit_idx;

  int tests = 0;
  int fails = 0;

  piso_8bit_tx dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start),
    .bit_idx(bit_idx), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted bytes queued at the accept, compared against a serial-in receiver.
  logic [7:0] exp_q[$];
  logic [7:0] rx;
  int         nbits = 0;
  int         rx_frames = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      nbits = 0;
    end else begin
      if (din_valid && din_ready) exp_q.push_back(din);
      if (sout_valid) begin
        rx = {rx[6:0], sout};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          rx_frames++;
          if (exp_q.size() == 0) chk("rx_unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
          else chk("rx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] b, input logic [7:0] exp_bits);
    int w = 0;
    while (!din_ready && w < 50) begin tick(); w++; end
    chk("single_ready_wait", {31'd0, din_ready}, 32'd1);
    din = b; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 8'h5A;
    chk("single_pre_valid", {31'd0, sout_valid}, 32'd0);
    chk("single_pre_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("single_valid", {31'd0, sout_valid}, 32'd1);
      chk("single_sout", {31'd0, sout}, {31'd0, exp_bits[7-i]});
      chk("single_fstart", {31'd0, frame_start}, (i == 0) ? 32'd1 : 32'd0);
      chk("single_bit_idx", {29'd0, bit_idx}, 32'(7 - i));
      chk("single_done_early", {31'd0, done}, 32'd0);
    end
    tick();
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    chk("single_valid_end", {31'd0, sout_valid}, 32'd0);
    tick();
    chk("single_done_pulse", {31'd0, done}, 32'd0);
  endtask

  // Holds din_valid high; while din_ready is low din is scrambled to prove it is not sampled.
  task automatic stream(input logic [7:0] bytes[$], output int stalls);
    int k = 0;
    int guard = 0;
    stalls = 0;
    while (k < bytes.size() && guard < 20000) begin
      din_valid = 1'b1;
      if (din_ready) begin
        din = bytes[k];
        k++;
      end else begin
        din = 8'($urandom);
        stalls++;
      end
      tick();
      guard++;
    end
    din_valid = 1'b0;
    chk("stream_all_sent", k, bytes.size());
    guard = 0;
    while (busy && guard < 40) begin tick(); guard++; end
    chk("stream_drained", {31'd0, busy}, 32'd0);
    tick();
    chk("stream_sb_empty", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] serial;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [7:0] bytes[$];
    logic [15:0] pat;
    int         stalls, f0;

    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h80, 8'b10000000};
    vecs[2] = '{8'h01, 8'b00000001};
    vecs[3] = '{8'hFF, 8'b11111111};
    vecs[4] = '{8'h3C, 8'b00111100};

    rst = 1'b1; din = 8'h00; din_valid = 1'b0;
    #3;
    chk("rst_sout", {31'd0, sout}, 32'd0);
    chk("rst_valid", {31'd0, sout_valid}, 32'd0);
    chk("rst_fstart", {31'd0, frame_start}, 32'd0);
    chk("rst_bit_idx", {29'd0, bit_idx}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    din_valid = 1'b1; din = 8'hEE;
    #20;
    chk("rst_held_busy", {31'd0, busy}, 32'd0);
    din_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) send_one(vecs[v].din, vecs[v].serial);

    // Back-to-back: 0x3C then 0xC3 with no gap.
    pat = 16'b0011110011000011;
    din = 8'h3C; din_valid = 1'b1;
    tick();
    din = 8'hC3;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_valid", {31'd0, sout_valid}, 32'd1);
      chk("b2b_sout", {31'd0, sout}, {31'd0, pat[15-i]});
      chk("b2b_fstart", {31'd0, frame_start}, (i == 0 || i == 8) ? 32'd1 : 32'd0);
      chk("b2b_done", {31'd0, done}, (i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b2b_done_end", {31'd0, done}, 32'd1);
    chk("b2b_valid_end", {31'd0, sout_valid}, 32'd0);
    tick();

    // Backpressure with scrambled din during stalls.
    f0 = rx_frames;
    bytes = '{8'h01, 8'h02, 8'h03};
    stream(bytes, stalls);
    chk("bp_stalled", {31'd0, (stalls > 0)}, 32'd1);
    chk("bp_frames", rx_frames - f0, 32'd3);

    // Reset mid-frame.
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mrst_sout", {31'd0, sout}, 32'd0);
    chk("mrst_valid", {31'd0, sout_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, din_ready}, 32'd1);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_no_done", {31'd0, done}, 32'd0);
    end
    send_one(8'h81, 8'b10000001);

    // Random loopback.
    f0 = rx_frames;
    bytes.delete();
    for (int i = 0; i < 256; i++) bytes.push_back(8'($urandom));
    stream(bytes, stalls);
    chk("loop_frames", rx_frames - f0, 32'd256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_8bit_tx.md
PISO_8BIT_TX -- requirements
Module: piso_8bit_tx

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  8  parallel byte to transmit.
REQ-005 din_valid  input  1  din is presented for transfer.
REQ-006 din_ready  output  1  block can accept din this cycle.
REQ-007 sout  output  1  serial data, MSB first.
REQ-008 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 frame_start  output  1  high in the cycle that drives bit 7 of a frame.
REQ-010 bit_idx  output  3  index of the din bit currently on sout.
REQ-011 done  output  1  one-cycle pulse after the last bit of a frame.
REQ-012 busy  output  1  frame in progress or byte waiting in holding buffer.

Function
REQ-013 Storage SHALL be a one-entry holding buffer (hold_data, hold_full), an 8-bit shift register shreg, a 3-bit counter cnt and an FSM with states IDLE and SHIFT.
REQ-014 Handshake: a byte SHALL be accepted on a rising edge where din_valid=1 and din_ready=1, and SHALL then be written to hold_data with hold_full set.
REQ-015 load SHALL be asserted when hold_full=1 and either state=IDLE, or state=SHIFT with cnt=7.
REQ-016 din_ready SHALL equal (!hold_full) | load, combinationally, so an accept and a buffer drain on the same edge are both allowed.
REQ-017 On a load edge: shreg<=hold_data, cnt<=0, state<=SHIFT; hold_full SHALL stay 1 only if a new byte is accepted on the same edge, otherwise it SHALL clear.
REQ-018 In SHIFT without load: shreg<=shreg<<1 (LSB filled with 0) and cnt<=cnt+1 each edge; at cnt=7 with no load, state<=IDLE.
REQ-019 sout SHALL equal shreg[7] in SHIFT and 0 in IDLE; sout_valid SHALL equal (state=SHIFT).
REQ-020 bit_idx SHALL equal 7-cnt in SHIFT and 0 in IDLE; frame_start SHALL equal (state=SHIFT and cnt=0).
REQ-021 done SHALL be a registered pulse, high for exactly one cycle after every edge that leaves cnt=7 in SHIFT, whether or not a reload occurs.
REQ-022 busy SHALL equal (state=SHIFT) | hold_full.
REQ-023 Latency: a byte accepted at edge N with the buffer empty and state=IDLE SHALL load at edge N+1 and drive bits 7..0 during cycles N+1..N+8; done SHALL be high in cycle N+9.
REQ-024 Back-to-back: if the holding buffer is full when cnt=7, the next frame's bit 7 SHALL follow the previous bit 0 with zero idle cycles, and sout_valid SHALL stay high continuously.
REQ-025 Ordering: after each 8-cycle sout_valid run, a receiver on the same clk that shifts sout in at out[0] and moves toward out[7] SHALL hold out[7:0]=din.
REQ-026 din_valid with din_ready=0 SHALL be ignored (no accept); din SHALL NOT be sampled.
REQ-027 A change in din or din_valid during SHIFT SHALL NOT alter the frame in flight.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE, shreg=0, cnt=0, hold_data=0, hold_full=0, done=0; outputs SHALL then be sout=0, sout_valid=0, frame_start=0, bit_idx=0, busy=0, din_ready=1.
REQ-029 If rst asserts mid-frame, the partial frame and any buffered byte SHALL be discarded, no done pulse SHALL be produced, and the first post-reset accept SHALL start a fresh frame per REQ-023.

Verification
REQ-030 Single byte: accept 0xA5 at edge N -> sout=1,0,1,0,0,1,0,1 over cycles N+1..N+8, frame_start only in N+1, done only in N+9, busy low from N+9.
REQ-031 Back-to-back: din_valid held high with 0x3C then 0xC3 -> 16 contiguous sout_valid cycles 0011110011000011; done pulses at end of each frame; second frame_start coincides with first done+... immediately after bit 0 of 0x3C.
REQ-032 Backpressure: din_valid held with 0x01, 0x02, 0x03 -> din_ready low while holding buffer full; no byte lost or duplicated; sout streams 0x01, 0x02, 0x03 in order.
REQ-033 Reset mid-frame: send 0xFF, assert rst after bit 3 -> sout=0, sout_valid=0, busy=0 immediately; no done; next byte 0x81 transmits cleanly.
REQ-034 Loopback: sout fed to an 8-bit serial-in shift register on the same clk, sampled on sout_valid -> after each frame, its out[7:0] equals the sent byte for 256 random bytes.
REQ-035 Ignored input: din_valid=1 while din_ready=0 with a changing din -> transmitted sequence unchanged.
